fault_latch: RTL and testbench

// Per-channel glitch filter and latch for the six raw CPLD fault comparators
// (BusOvp, IP_Ocp, InvOcp1, OP_Ovp1, InvOcp2, OP_Ovp2). It sits directly

---
 rtl/fault_latch_if.sv | 30 +++
 rtl/fault_latch.sv | 130 +++++++++++++
 tb/tb_fault_latch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fault_latch_if.sv
// Fault bus between the raw comparator/DSP side and the fault latch block.
// The master drives the raw faults and the clear request; the slave returns the latched status.
interface fault_latch_if #(
    parameter int N_CH = 6
);
    logic [N_CH-1:0] flt_raw;
    logic            flt_clr;
    logic [N_CH-1:0] flt_lat;
    logic            pwm_kill;
    logic [2:0]      first_id;
    logic            clr_rej;

    modport master (
        output flt_raw,
        output flt_clr,
        input  flt_lat,
        input  pwm_kill,
        input  first_id,
        input  clr_rej
    );

    modport slave (
        input  flt_raw,
        input  flt_clr,
        output flt_lat,
        output pwm_kill,
        output first_id,
        output clr_rej
    );
endinterface

// File: rtl/fault_latch.sv
// Per-channel glitch filter and fault latch with PWM kill, first-fault capture
// and DSP clear handling (clears are refused while the synced fault is still high).
module fault_latch #(
    parameter int N_CH     = 6,
    parameter int FILT_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    fault_latch_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FILT, LATCHED} state_e;

    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  s_q;
    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [2:0]       first_id_q;
    logic [2:0]       first_id_d;
    logic             clr_rej_q;
    logic             clr_rej_d;
    logic [N_CH-1:0]  latchNow;
    logic [N_CH-1:0]  latNext;
    logic [N_CH-1:0]  latVec;

    // State register: synchroniser, channel FSMs, first-fault id and reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            s_q        <= '0;
            first_id_q <= '0;
            clr_rej_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q    <= bus.flt_raw;
            s_q        <= sync1_q;
            first_id_q <= first_id_d;
            clr_rej_q  <= clr_rej_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic. A channel only looks at the clear once it is already latched,
    // so a clear arriving on the latching cycle cannot cancel or reject that latch.
    always_comb begin
        latchNow  = '0;
        latNext   = '0;
        clr_rej_d = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (s_q[i]) begin
                        if (FILT_CYC == 1) begin
                            state_d[i]  = LATCHED;
                            cnt_d[i]    = '0;
                            latchNow[i] = 1'b1;
                        end else begin
                            state_d[i] = FILT;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                FILT: begin
                    if (!s_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(FILT_CYC - 1)) begin
                        state_d[i]  = LATCHED;
                        cnt_d[i]    = '0;
                        latchNow[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                LATCHED: begin
                    if (bus.flt_clr) begin
                        if (!s_q[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            clr_rej_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            latNext[i] = (state_d[i] == LATCHED);
        end

        // Descending scan so the lowest simultaneously latching channel wins.
        first_id_d = first_id_q;
        if (latNext == '0) begin
            first_id_d = '0;
        end else if (first_id_q == '0) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (latchNow[i]) begin
                    first_id_d = 3'(i + 1);
                end
            end
        end
    end

    // Outputs decode straight from the state registers, so pwm_kill adds no latency.
    always_comb begin
        latVec = '0;
        for (int i = 0; i < N_CH; i++) begin
            latVec[i] = (state_q[i] == LATCHED);
        end
    end

    assign bus.flt_lat  = latVec;
    assign bus.pwm_kill = |latVec;
    assign bus.first_id = first_id_q;
    assign bus.clr_rej  = clr_rej_q;

endmodule

// File: tb/tb_fault_latch.sv
// Self-checking bench for fault_latch: directed scenarios followed by random traffic,
// all compared every cycle against a run-length reference model of the fault filter.
module tb_fault_latch;

    localparam int N_CH     = 6;
    localparam int FILT_CYC = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fault_latch_if #(.N_CH(N_CH)) bus ();

    fault_latch #(.N_CH(N_CH), .FILT_CYC(FILT_CYC), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw history for the two-stage delay, and per channel the
    // length of the current unbroken run of synced-high cycles plus a latched flag.
    logic [N_CH-1:0] rawPrev1;
    logic [N_CH-1:0] rawPrev2;
    int              runLen [N_CH];
    bit              isLatched [N_CH];
    int              firstModel;
    bit              rejModel;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        rawPrev1   = '0;
        rawPrev2   = '0;
        firstModel = 0;
        rejModel   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            runLen[i]    = 0;
            isLatched[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input logic [N_CH-1:0] raw, input logic clr);
        logic [N_CH-1:0] synced;
        logic [N_CH-1:0] newly;
        bit              anyLatched;
        synced   = rawPrev2;
        newly    = '0;
        rejModel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (isLatched[i]) begin
                if (clr && !synced[i]) begin
                    isLatched[i] = 1'b0;
                    runLen[i]    = 0;
                end else if (clr) begin
                    rejModel = 1'b1;
                end
            end else if (synced[i]) begin
                runLen[i]++;
                if (runLen[i] >= FILT_CYC) begin
                    isLatched[i] = 1'b1;
                    runLen[i]    = 0;
                    newly[i]     = 1'b1;
                end
            end else begin
                runLen[i] = 0;
            end
        end
        anyLatched = 1'b0;
        for (int i = 0; i < N_CH; i++) anyLatched |= isLatched[i];
        if (!anyLatched) begin
            firstModel = 0;
        end else if (firstModel == 0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (newly[i] && firstModel == 0) firstModel = i + 1;
            end
        end
        rawPrev2 = rawPrev1;
        rawPrev1 = raw;
    endtask

    // Drives inputs, then clocks n cycles; each edge advances the model and compares outputs.
    task automatic applyStimulus(input logic [N_CH-1:0] raw, input logic clr,
                                 input logic rstV, input int n);
        logic [N_CH-1:0] expLat;
        bus.flt_raw = raw;
        bus.flt_clr = clr;
        rst         = rstV;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (rstV) modelReset();
            else      modelStep(raw, clr);
            #1;
            expLat = '0;
            for (int i = 0; i < N_CH; i++) expLat[i] = isLatched[i];
            checkOutput("flt_lat",  32'(bus.flt_lat),  32'(expLat));
            checkOutput("pwm_kill", 32'(bus.pwm_kill), 32'(|expLat));
            checkOutput("first_id", 32'(bus.first_id), 32'(firstModel));
            checkOutput("clr_rej",  32'(bus.clr_rej),  32'(rejModel));
        end
    endtask

    initial begin
        logic [N_CH-1:0] rnd;
        checks = 0;
        errors = 0;
        modelReset();
        bus.flt_raw = '0;
        bus.flt_clr = 1'b0;
        rst         = 1'b1;

        applyStimulus('0, 1'b0, 1'b1, 2);
        applyStimulus('0, 1'b0, 1'b0, 1);
        checkOutput("reset_lat",   32'(bus.flt_lat),  32'h0);
        checkOutput("reset_first", 32'(bus.first_id), 32'h0);

        $display("[TB] glitch of 7 cycles on channel 2");
        applyStimulus(6'b000100, 1'b0, 1'b0, 7);
        applyStimulus(6'b000000, 1'b0, 1'b0, 12);
        checkOutput("glitch_lat",  32'(bus.flt_lat),  32'h0);
        checkOutput("glitch_kill", 32'(bus.pwm_kill), 32'h0);

        $display("[TB] latch channel 0 with exact latency");
        applyStimulus(6'b000001, 1'b0, 1'b0, 9);
        checkOutput("latch_early", 32'(bus.flt_lat), 32'h0);
        applyStimulus(6'b000001, 1'b0, 1'b0, 1);
        checkOutput("latch_lat",   32'(bus.flt_lat),  32'h01);
        checkOutput("latch_kill",  32'(bus.pwm_kill), 32'h1);
        checkOutput("latch_first", 32'(bus.first_id), 32'h1);
        applyStimulus(6'b000000, 1'b0, 1'b0, 5);
        checkOutput("latch_hold",  32'(bus.flt_lat), 32'h01);
        applyStimulus(6'b000000, 1'b1, 1'b0, 1);
        applyStimulus(6'b000000, 1'b0, 1'b0, 2);

        $display("[TB] simultaneous channels 1 and 4");
        applyStimulus(6'b010010, 1'b0, 1'b0, 12);
        checkOutput("simul_lat",   32'(bus.flt_lat),  32'h12);
        checkOutput("simul_first", 32'(bus.first_id), 32'h2);
        applyStimulus(6'b000000, 1'b0, 1'b0, 3);
        applyStimulus(6'b000000, 1'b1, 1'b0, 1);
        applyStimulus(6'b000000, 1'b0, 1'b0, 2);

        $display("[TB] refused and accepted clear on channel 3");
        applyStimulus(6'b001000, 1'b0, 1'b0, 12);
        applyStimulus(6'b001000, 1'b1, 1'b0, 1);
        checkOutput("rej_pulse", 32'(bus.clr_rej), 32'h1);
        checkOutput("rej_lat",   32'(bus.flt_lat), 32'h08);
        applyStimulus(6'b000000, 1'b0, 1'b0, 1);
        checkOutput("rej_end",   32'(bus.clr_rej), 32'h0);
        applyStimulus(6'b000000, 1'b0, 1'b0, 2);
        applyStimulus(6'b000000, 1'b1, 1'b0, 1);
        checkOutput("clr_lat",   32'(bus.flt_lat),  32'h0);
        checkOutput("clr_first", 32'(bus.first_id), 32'h0);
        checkOutput("clr_kill",  32'(bus.pwm_kill), 32'h0);

        $display("[TB] clear racing the latch of channel 5");
        applyStimulus(6'b100000, 1'b0, 1'b0, 9);
        applyStimulus(6'b100000, 1'b1, 1'b0, 1);
        checkOutput("race_lat", 32'(bus.flt_lat), 32'h20);
        checkOutput("race_rej", 32'(bus.clr_rej), 32'h0);
        applyStimulus(6'b000000, 1'b0, 1'b0, 1);
        checkOutput("race_rej_next", 32'(bus.clr_rej), 32'h0);
        applyStimulus(6'b000000, 1'b0, 1'b0, 3);
        applyStimulus(6'b000000, 1'b1, 1'b0, 1);
        applyStimulus(6'b000000, 1'b0, 1'b0, 1);

        $display("[TB] reset with channel 0 latched and still faulted");
        applyStimulus(6'b000001, 1'b0, 1'b0, 12);
        applyStimulus(6'b000001, 1'b0, 1'b1, 1);
        checkOutput("rst_lat",   32'(bus.flt_lat),  32'h0);
        checkOutput("rst_first", 32'(bus.first_id), 32'h0);
        applyStimulus(6'b000001, 1'b0, 1'b0, 9);
        checkOutput("relatch_early", 32'(bus.flt_lat), 32'h0);
        applyStimulus(6'b000001, 1'b0, 1'b0, 1);
        checkOutput("relatch_lat",   32'(bus.flt_lat), 32'h01);

        $display("[TB] random traffic");
        rnd = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 9) == 0) rnd[i] = ~rnd[i];
            end
            applyStimulus(rnd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
